// File: rtl/ring_counter_pkg.sv
// Shared constants and pure helpers for the rotating-token counter.
package ring_counter_pkg;

  // Topology select values for the JOHNSON parameter.
  localparam bit MODE_RING    = 1'b0;
  localparam bit MODE_JOHNSON = 1'b1;

  // Rotation direction values for the DIR input.
  localparam bit DIR_UP   = 1'b0;
  localparam bit DIR_DOWN = 1'b1;

  // Widest state vector the helpers accept; narrower states are zero-extended.
  localparam int unsigned MaxWidth = 64;

  // Number of set bits in v.
  function automatic int unsigned popcount(input logic [MaxWidth-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // A Johnson state has at most one boundary between its run of ones and zeros.
  // Only the low 'width' bits take part.
  function automatic logic johnson_legal(input logic [MaxWidth-1:0] v,
                                         input int unsigned         width);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i + 1 < MaxWidth; i++) begin
      if ((i + 1 < width) && (v[i] != v[i+1])) n++;
    end
    return (n <= 1);
  endfunction

endpackage

// File: rtl/ring_legal_check.sv
// Combinational legality test of a counter state against its topology.
module ring_legal_check
  import ring_counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] INIT    = WIDTH'(1),
  parameter bit               JOHNSON = MODE_RING
) (
  input  logic [WIDTH-1:0] state_i,
  output logic             legal_o
);

  // A ring never creates or destroys tokens, so the token count must match INIT.
  localparam int unsigned InitOnes = popcount(MaxWidth'(INIT));

  logic [MaxWidth-1:0] state_ext;
  assign state_ext = MaxWidth'(state_i);

  // Select the legality rule for the configured topology.
  always_comb begin
    legal_o = 1'b0;
    if (JOHNSON == MODE_JOHNSON) begin
      legal_o = johnson_legal(state_ext, WIDTH);
    end else begin
      legal_o = (popcount(state_ext) == InitOnes);
    end
  end

endmodule

// File: rtl/ring_shift_counter.sv
// Rotating-token counter: ring or Johnson topology, runtime direction,
// clock enable, parallel load, wrap pulse and optional illegal-state recovery.
// WIDTH must be >= 2 and no larger than ring_counter_pkg::MaxWidth.
module ring_shift_counter
  import ring_counter_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] INIT         = WIDTH'(1),
  parameter bit               JOHNSON      = MODE_RING,
  parameter bit               SELF_CORRECT = 1'b1
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             CE,
  input  logic             DIR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] O,
  output logic             WRAP,
  output logic             ERR
);

  logic [WIDTH-1:0] state_q, state_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             legal;
  logic [WIDTH-1:0] rotated;
  logic             fb_up, fb_down;

  // Without self-correction every state is accepted, so ERR can never fire.
  if (SELF_CORRECT) begin : g_check
    ring_legal_check #(
      .WIDTH   (WIDTH),
      .INIT    (INIT),
      .JOHNSON (JOHNSON)
    ) u_legal (
      .state_i (state_q),
      .legal_o (legal)
    );
  end else begin : g_no_check
    assign legal = 1'b1;
  end

  // Rotate one position; Johnson inverts the bit wrapping around the end.
  always_comb begin
    fb_up   = state_q[WIDTH-1] ^ (JOHNSON == MODE_JOHNSON);
    fb_down = state_q[0] ^ (JOHNSON == MODE_JOHNSON);
    rotated = state_q;
    if (DIR == DIR_DOWN) begin
      rotated = {fb_down, state_q[WIDTH-1:1]};
    end else begin
      rotated = {state_q[WIDTH-2:0], fb_up};
    end
  end

  // Next state: load beats step beats hold; pulses clear unless re-asserted.
  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (LOAD) begin
      // Loaded value is trusted here and only validated on the next step.
      state_d = D;
    end else if (CE) begin
      if (!legal) begin
        state_d = INIT;
        err_d   = 1'b1;
      end else begin
        state_d = rotated;
        wrap_d  = (rotated == INIT);
      end
    end
  end

  // State and pulse registers; reset restores INIT without a clock edge.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= INIT;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign O    = state_q;
  assign WRAP = wrap_q;
  assign ERR  = err_q;

endmodule
